// File: rtl/facto_pkg.sv
// Shared definitions for the FactoCore host sequencer: register offsets and FSM states.
// FactoCore itself decodes the same offsets relative to its base address.
package facto_pkg;

    localparam logic [15:0] OFS_OPSTART  = 16'h0000;
    localparam logic [15:0] OFS_OPCLEAR  = 16'h0008;
    localparam logic [15:0] OFS_OPDONE   = 16'h0010;
    localparam logic [15:0] OFS_INTREN   = 16'h0018;
    localparam logic [15:0] OFS_OPERAND  = 16'h0020;
    localparam logic [15:0] OFS_RESULT_H = 16'h0028;
    localparam logic [15:0] OFS_RESULT_L = 16'h0030;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_W_CLR,
        ST_W_IEN,
        ST_W_OPND,
        ST_W_START,
        ST_WAIT_INT,
        ST_RD_H,
        ST_RD_L,
        ST_W_CLR2,
        ST_RSP
    } seq_state_e;

endpackage

// File: rtl/bus_master_if.sv
// Single-access bus engine: a go pulse launches a 1-cycle write or a 2-cycle read.
// o_done marks the last cycle of an access; on a read, o_rdata is valid in that cycle.
module bus_master_if (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_go,
    input  logic        i_wr,
    input  logic [15:0] i_addr,
    input  logic [63:0] i_wdata,
    output logic        o_done,
    output logic [63:0] o_rdata,
    output logic        o_m_sel,
    output logic        o_m_wr,
    output logic [15:0] o_m_addr,
    output logic [63:0] o_m_dout,
    input  logic [63:0] i_m_din
);

    logic        r_sel;
    logic        r_wr;
    logic [15:0] r_addr;
    logic [63:0] r_dout;
    logic        r_phase;

    // A read holds the address for a second cycle; anything else returns the bus to all-zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel   <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_dout  <= '0;
            r_phase <= 1'b0;
        end else if (i_go) begin
            r_sel   <= 1'b1;
            r_wr    <= i_wr;
            r_addr  <= i_addr;
            r_dout  <= i_wr ? i_wdata : 64'd0;
            r_phase <= 1'b0;
        end else if (r_sel && !r_wr && !r_phase) begin
            r_phase <= 1'b1;
        end else begin
            r_sel   <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_dout  <= '0;
            r_phase <= 1'b0;
        end
    end

    assign o_done   = r_sel && (r_wr || r_phase);
    assign o_rdata  = i_m_din;
    assign o_m_sel  = r_sel;
    assign o_m_wr   = r_wr;
    assign o_m_addr = r_addr;
    assign o_m_dout = r_dout;

endmodule

// File: rtl/facto_host_seq.sv
// Bus-master sequencer that runs one FactoCore factorial job per request and returns
// the 128-bit result (or a timeout error) on a valid/ready response port.
module facto_host_seq
    import facto_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h7000,
    parameter int          TIMEOUT   = 4096,
    parameter int          CNT_W     = 13
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [63:0]  req_operand,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_result,
    output logic         rsp_err,
    output logic         busy,
    output logic         m_sel,
    output logic         m_wr,
    output logic [15:0]  m_addr,
    output logic [63:0]  m_dout,
    input  logic [63:0]  m_din,
    input  logic         interrupt
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    seq_state_e       r_state;
    seq_state_e       w_next;
    logic [63:0]      r_operand;
    logic [CNT_W-1:0] r_cnt;
    logic [63:0]      r_res_h;
    logic [63:0]      r_res_l;
    logic             r_err;
    logic             r_req_ready;
    logic             r_busy;
    logic             r_rsp_valid;

    logic             w_go;
    logic             w_wr;
    logic [15:0]      w_addr;
    logic [63:0]      w_wdata;
    logic             w_done;
    logic [63:0]      w_rdata;
    logic             w_accept;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_timeout;
    logic             w_cap_h;
    logic             w_cap_l;

    bus_master_if u_bus (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_go     (w_go),
        .i_wr     (w_wr),
        .i_addr   (w_addr),
        .i_wdata  (w_wdata),
        .o_done   (w_done),
        .o_rdata  (w_rdata),
        .o_m_sel  (m_sel),
        .o_m_wr   (m_wr),
        .o_m_addr (m_addr),
        .o_m_dout (m_dout),
        .i_m_din  (m_din)
    );

    // Accesses are launched on the transition into a state so that each bus cycle
    // lines up with the state that owns it.
    always_comb begin
        w_next    = r_state;
        w_go      = 1'b0;
        w_wr      = 1'b0;
        w_addr    = '0;
        w_wdata   = '0;
        w_accept  = 1'b0;
        w_cnt_clr = 1'b0;
        w_cnt_inc = 1'b0;
        w_timeout = 1'b0;
        w_cap_h   = 1'b0;
        w_cap_l   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_accept = 1'b1;
                    w_next   = ST_W_CLR;
                    w_go     = 1'b1;
                    w_wr     = 1'b1;
                    w_addr   = BASE_ADDR + OFS_OPCLEAR;
                    w_wdata  = 64'd1;
                end
            end
            ST_W_CLR: begin
                w_next  = ST_W_IEN;
                w_go    = 1'b1;
                w_wr    = 1'b1;
                w_addr  = BASE_ADDR + OFS_INTREN;
                w_wdata = 64'd1;
            end
            ST_W_IEN: begin
                w_next  = ST_W_OPND;
                w_go    = 1'b1;
                w_wr    = 1'b1;
                w_addr  = BASE_ADDR + OFS_OPERAND;
                w_wdata = r_operand;
            end
            ST_W_OPND: begin
                w_next  = ST_W_START;
                w_go    = 1'b1;
                w_wr    = 1'b1;
                w_addr  = BASE_ADDR + OFS_OPSTART;
                w_wdata = 64'd1;
            end
            ST_W_START: begin
                w_next    = ST_WAIT_INT;
                w_cnt_clr = 1'b1;
            end
            ST_WAIT_INT: begin
                if (interrupt) begin
                    w_next = ST_RD_H;
                    w_go   = 1'b1;
                    w_addr = BASE_ADDR + OFS_RESULT_H;
                end else if (r_cnt == LAST_CNT) begin
                    w_next    = ST_W_CLR2;
                    w_timeout = 1'b1;
                    w_go      = 1'b1;
                    w_wr      = 1'b1;
                    w_addr    = BASE_ADDR + OFS_OPCLEAR;
                    w_wdata   = 64'd1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            ST_RD_H: begin
                if (w_done) begin
                    w_cap_h = 1'b1;
                    w_next  = ST_RD_L;
                    w_go    = 1'b1;
                    w_addr  = BASE_ADDR + OFS_RESULT_L;
                end
            end
            ST_RD_L: begin
                if (w_done) begin
                    w_cap_l = 1'b1;
                    w_next  = ST_W_CLR2;
                    w_go    = 1'b1;
                    w_wr    = 1'b1;
                    w_addr  = BASE_ADDR + OFS_OPCLEAR;
                    w_wdata = 64'd1;
                end
            end
            ST_W_CLR2: w_next = ST_RSP;
            ST_RSP: begin
                if (rsp_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Result registers are zeroed at job acceptance, so a timeout naturally reports zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_operand   <= '0;
            r_cnt       <= '0;
            r_res_h     <= '0;
            r_res_l     <= '0;
            r_err       <= 1'b0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_req_ready <= (w_next == ST_IDLE);
            r_busy      <= (w_next != ST_IDLE);
            r_rsp_valid <= (w_next == ST_RSP);
            if (w_accept) begin
                r_operand <= req_operand;
                r_res_h   <= '0;
                r_res_l   <= '0;
                r_err     <= 1'b0;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_timeout) r_err   <= 1'b1;
            if (w_cap_h)   r_res_h <= w_rdata;
            if (w_cap_l)   r_res_l <= w_rdata;
        end
    end

    assign req_ready  = r_req_ready;
    assign busy       = r_busy;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = {r_res_h, r_res_l};
    assign rsp_err    = r_err;

endmodule

// File: tb/tb_facto_host_seq.sv
// Self-checking bench for facto_host_seq with a behavioural FactoCore slave model,
// a bus transaction log and randomized factorial jobs.
module tb_facto_host_seq;

    localparam int TB_TIMEOUT = 64;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [63:0]  req_operand = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [127:0] rsp_result;
    logic         rsp_err;
    logic         busy;
    logic         m_sel;
    logic         m_wr;
    logic [15:0]  m_addr;
    logic [63:0]  m_dout;
    logic [63:0]  m_din;
    logic         interrupt;

    int nChecks = 0;
    int nPass = 0;
    int cycleNo = 0;

    facto_host_seq #(
        .BASE_ADDR (16'h7000),
        .TIMEOUT   (TB_TIMEOUT),
        .CNT_W     (13)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_operand (req_operand),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .m_sel       (m_sel),
        .m_wr        (m_wr),
        .m_addr      (m_addr),
        .m_dout      (m_dout),
        .m_din       (m_din),
        .interrupt   (interrupt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleNo <= cycleNo + 1;

    function automatic logic [127:0] fact(input logic [63:0] n);
        logic [127:0] r = 128'd1;
        for (int i = 2; 64'(i) <= n; i++) r = r * 128'(i);
        return r;
    endfunction

    // Behavioural FactoCore: decodes writes, finishes a random number of cycles after start.
    logic [127:0] coreResult = '0;
    logic [63:0]  coreOperand = '0;
    logic         coreDone = 1'b0;
    logic         coreIen = 1'b0;
    int           coreDelay = 0;
    bit           irqEnable = 1'b1;

    always @(negedge clk) begin
        if (coreDelay > 0) begin
            coreDelay <= coreDelay - 1;
            if (coreDelay == 1) begin
                coreDone   <= 1'b1;
                coreResult <= fact(coreOperand);
            end
        end
        if (m_sel && m_wr) begin
            case (m_addr)
                16'h7008: begin
                    coreDone   <= 1'b0;
                    coreDelay  <= 0;
                    coreResult <= '0;
                end
                16'h7018: coreIen     <= m_dout[0];
                16'h7020: coreOperand <= m_dout;
                16'h7000: coreDelay   <= int'($urandom_range(3, 20));
                default: ;
            endcase
        end
    end

    assign interrupt = coreDone && coreIen && irqEnable;
    assign m_din = (m_addr == 16'h7028) ? coreResult[127:64] :
                   (m_addr == 16'h7030) ? coreResult[63:0] : 64'd0;

    // Bus monitor: logs completed accesses and counts protocol violations.
    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [63:0] data;
        int          cyc;
    } bus_rec_t;

    bus_rec_t    busLog[$];
    int          busViolations = 0;
    int          readRun = 0;
    logic [15:0] readAddr = '0;

    always @(negedge clk) begin
        if (m_sel && !m_wr) begin
            if (readRun > 0 && m_addr == readAddr) begin
                readRun++;
            end else begin
                if (readRun != 0 && readRun != 2) busViolations++;
                readRun  = 1;
                readAddr = m_addr;
            end
            if (readRun == 2) busLog.push_back('{wr: 1'b0, addr: m_addr, data: m_din, cyc: cycleNo});
        end else begin
            if (readRun != 0 && readRun != 2) busViolations++;
            readRun = 0;
        end
        if (m_sel && m_wr) busLog.push_back('{wr: 1'b1, addr: m_addr, data: m_dout, cyc: cycleNo});
        if (!m_sel && (m_wr || m_addr != 16'd0 || m_dout != 64'd0)) busViolations++;
    end

    task automatic reqJob(input logic [63:0] n, output bit ok);
        int waited = 0;
        @(negedge clk);
        req_valid   = 1'b1;
        req_operand = n;
        while (!req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        ok = req_ready;
        @(negedge clk);
        req_valid   = 1'b0;
        req_operand = 64'($urandom);
    endtask

    task automatic getRsp(input int stall, output logic [127:0] res, output logic err, output bit ok);
        int waited = 0;
        @(negedge clk);
        while (!rsp_valid && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        ok  = rsp_valid;
        res = rsp_result;
        err = rsp_err;
        repeat (stall) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        nChecks++;
        if ({req_ready, busy, rsp_valid, rsp_err, m_sel, m_wr} !== 6'b0)
            $display("[TB] FAIL reset_ctrl: got %b expected 000000", {req_ready, busy, rsp_valid, rsp_err, m_sel, m_wr});
        else nPass++;
        nChecks++;
        if ({m_addr, m_dout, rsp_result} !== 208'd0)
            $display("[TB] FAIL reset_data: addr %h dout %h result %h expected all 0", m_addr, m_dout, rsp_result);
        else nPass++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        nChecks++;
        if ({req_ready, busy} !== 2'b10)
            $display("[TB] FAIL reset_release: req_ready/busy got %b expected 10", {req_ready, busy});
        else nPass++;
    endtask

    task automatic test_basic();
        logic [127:0] res;
        logic err;
        bit okReq, okRsp;
        logic [15:0] expAddr [7] = '{16'h7008, 16'h7018, 16'h7020, 16'h7000, 16'h7028, 16'h7030, 16'h7008};
        bit          expWr   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [63:0] expData [7] = '{64'd1, 64'd1, 64'd5, 64'd1, 64'd0, 64'd0, 64'd1};
        busLog.delete();
        reqJob(64'd5, okReq);
        getRsp(0, res, err, okRsp);
        nChecks++;
        if (!(okReq && okRsp)) $display("[TB] FAIL basic_handshake: req %0d rsp %0d expected 1 1", okReq, okRsp);
        else nPass++;
        nChecks++;
        if (res !== 128'd120 || err !== 1'b0) $display("[TB] FAIL basic_fact5: got %0d err %b expected 120 err 0", res, err);
        else nPass++;
        nChecks++;
        if (busLog.size() != 7) $display("[TB] FAIL basic_buscount: got %0d expected 7", busLog.size());
        else nPass++;
        for (int i = 0; i < 7 && i < busLog.size(); i++) begin
            nChecks++;
            if (busLog[i].wr !== expWr[i] || busLog[i].addr !== expAddr[i] || (expWr[i] && busLog[i].data !== expData[i]))
                $display("[TB] FAIL basic_bus%0d: got wr %b addr %h data %0d expected wr %b addr %h data %0d",
                         i, busLog[i].wr, busLog[i].addr, busLog[i].data, expWr[i], expAddr[i], expData[i]);
            else nPass++;
        end
    endtask

    task automatic test_known_values();
        logic [63:0]  nTab [4] = '{64'd10, 64'd0, 64'd1, 64'd25};
        logic [127:0] eTab [4] = '{128'd3628800, 128'd1, 128'd1, 128'd15511210043330985984000000};
        logic [127:0] res;
        logic err;
        bit okReq, okRsp;
        for (int k = 0; k < 4; k++) begin
            busLog.delete();
            reqJob(nTab[k], okReq);
            getRsp(k, res, err, okRsp);
            nChecks++;
            if (!(okReq && okRsp) || res !== eTab[k] || err !== 1'b0)
                $display("[TB] FAIL known_n%0d: got %0d err %b expected %0d err 0", nTab[k], res, err, eTab[k]);
            else nPass++;
        end
        nChecks++;
        if (res[127:64] == 64'd0) $display("[TB] FAIL fact25_high: got high word 0 expected nonzero");
        else nPass++;
        nChecks++;
        if (busLog.size() < 6 || busLog[4].addr !== 16'h7028 || busLog[5].addr !== 16'h7030)
            $display("[TB] FAIL read_order: got log size %0d, expected reads 7028 then 7030", busLog.size());
        else nPass++;
    endtask

    task automatic test_random();
        logic [127:0] res;
        logic err;
        bit okReq, okRsp;
        logic [63:0] n;
        for (int k = 0; k < 6; k++) begin
            n = 64'($urandom_range(0, 34));
            reqJob(n, okReq);
            getRsp(int'($urandom_range(0, 5)), res, err, okRsp);
            nChecks++;
            if (!(okReq && okRsp) || res !== fact(n) || err !== 1'b0)
                $display("[TB] FAIL random_n%0d: got %0d err %b expected %0d err 0", n, res, err, fact(n));
            else nPass++;
        end
    endtask

    task automatic test_stall();
        bit okReq;
        int waited = 0;
        logic [127:0] held;
        int bad = 0;
        reqJob(64'd6, okReq);
        while (!rsp_valid && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        held = rsp_result;
        nChecks++;
        if (!okReq || !rsp_valid || held !== 128'd720)
            $display("[TB] FAIL stall_first: valid %b result %0d expected 1 720", rsp_valid, held);
        else nPass++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_result !== held || rsp_err !== 1'b0 || req_ready !== 1'b0) bad++;
        end
        nChecks++;
        if (bad != 0) $display("[TB] FAIL stall_hold: got %0d unstable cycles expected 0", bad);
        else nPass++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        nChecks++;
        if ({rsp_valid, req_ready} !== 2'b01)
            $display("[TB] FAIL stall_release: rsp_valid/req_ready got %b expected 01", {rsp_valid, req_ready});
        else nPass++;
    endtask

    task automatic test_timeout();
        logic [127:0] res;
        logic err;
        bit okReq, okRsp;
        irqEnable = 1'b0;
        busLog.delete();
        reqJob(64'd7, okReq);
        getRsp(2, res, err, okRsp);
        irqEnable = 1'b1;
        nChecks++;
        if (!(okReq && okRsp) || err !== 1'b1 || res !== 128'd0)
            $display("[TB] FAIL timeout_rsp: got result %0d err %b expected 0 err 1", res, err);
        else nPass++;
        nChecks++;
        if (busLog.size() != 5 || busLog[4].addr !== 16'h7008 || busLog[4].wr !== 1'b1)
            $display("[TB] FAIL timeout_clear: got log size %0d expected 5 ending with write 7008", busLog.size());
        else nPass++;
        if (busLog.size() == 5) begin
            nChecks++;
            if (busLog[4].cyc - busLog[3].cyc != TB_TIMEOUT + 1)
                $display("[TB] FAIL timeout_len: got %0d cycles start-to-clear expected %0d",
                         busLog[4].cyc - busLog[3].cyc, TB_TIMEOUT + 1);
            else nPass++;
        end
    endtask

    task automatic test_reset_midjob();
        logic [127:0] res;
        logic err;
        bit okReq, okRsp;
        int waited = 0;
        busLog.delete();
        reqJob(64'd9, okReq);
        while (busLog.size() < 4 && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        @(posedge clk);
        #2;
        nChecks++;
        if (!okReq || busy !== 1'b1) $display("[TB] FAIL midjob_busy: got %b expected 1", busy);
        else nPass++;
        reset_n = 1'b0;
        #1;
        nChecks++;
        if ({req_ready, busy, rsp_valid, m_sel, m_wr, m_addr, m_dout} !== 85'd0)
            $display("[TB] FAIL midjob_async: ready %b busy %b valid %b sel %b addr %h expected all 0",
                     req_ready, busy, rsp_valid, m_sel, m_addr);
        else nPass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        busLog.delete();
        reqJob(64'd3, okReq);
        getRsp(0, res, err, okRsp);
        nChecks++;
        if (!(okReq && okRsp) || res !== 128'd6 || err !== 1'b0 || busLog.size() != 7)
            $display("[TB] FAIL midjob_next: got %0d err %b log %0d expected 6 err 0 log 7", res, err, busLog.size());
        else nPass++;
    endtask

    task automatic test_back_to_back();
        logic [127:0] res;
        logic err;
        bit okReq, okRsp;
        int waited = 0;
        reqJob(64'd4, okReq);
        while (!rsp_valid && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        nChecks++;
        if (!okReq || rsp_result !== 128'd24 || req_ready !== 1'b0)
            $display("[TB] FAIL b2b_first: got %0d ready %b expected 24 ready 0", rsp_result, req_ready);
        else nPass++;
        rsp_ready   = 1'b1;
        req_valid   = 1'b1;
        req_operand = 64'd8;
        @(negedge clk);
        rsp_ready = 1'b0;
        nChecks++;
        if ({req_ready, rsp_valid} !== 2'b10)
            $display("[TB] FAIL b2b_ready: req_ready/rsp_valid got %b expected 10", {req_ready, rsp_valid});
        else nPass++;
        @(negedge clk);
        req_valid = 1'b0;
        nChecks++;
        if ({req_ready, busy} !== 2'b01)
            $display("[TB] FAIL b2b_accept: req_ready/busy got %b expected 01", {req_ready, busy});
        else nPass++;
        getRsp(1, res, err, okRsp);
        nChecks++;
        if (!okRsp || res !== 128'd40320 || err !== 1'b0)
            $display("[TB] FAIL b2b_second: got %0d err %b expected 40320 err 0", res, err);
        else nPass++;
    endtask

    task automatic test_bus_protocol();
        nChecks++;
        if (busViolations != 0) $display("[TB] FAIL bus_protocol: got %0d violations expected 0", busViolations);
        else nPass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_known_values();
        test_random();
        test_stall();
        test_timeout();
        test_reset_midjob();
        test_back_to_back();
        test_bus_protocol();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
